// File: rtl/medidor_de_frecuencia.sv
// Frequency meter: counts clk_periodo cycles between rising edges of a square wave and
// converts the period to Hz with a restoring divider (one quotient bit per cycle).
module medidor_de_frecuencia #(
   parameter int unsigned CLK_HZ        = 12000000,
   parameter int unsigned ANCHO_DIV     = 24,
   parameter int unsigned ANCHO_PERIODO = 20,
   parameter int unsigned MAX_PERIODO   = 600000,
   parameter int unsigned TONO_MAX      = 1023
) (
   input  logic       clk_periodo,
   input  logic       reset,
   input  logic       onda_entrada,
   output logic [9:0] tono,
   output logic       tono_valido,
   output logic       silencio,
   output logic       ocupado
);

   localparam int unsigned AC = $clog2(ANCHO_DIV);
   localparam logic [ANCHO_DIV-1:0]     DIVIDENDO = ANCHO_DIV'(CLK_HZ);
   localparam logic [ANCHO_DIV-1:0]     TMAX      = ANCHO_DIV'(TONO_MAX);
   localparam logic [9:0]               TMAX10    = 10'(TONO_MAX);
   localparam logic [ANCHO_PERIODO-1:0] CNT_MAX   = ANCHO_PERIODO'(MAX_PERIODO);
   localparam logic [ANCHO_PERIODO:0]   UNO       = (ANCHO_PERIODO+1)'(1);
   localparam logic [AC-1:0]            IT_ULT    = AC'(ANCHO_DIV-1);

   typedef enum logic [1:0] {ESPERA, MIDIENDO, DIVIDIENDO} estado_t;

   estado_t                  est_q, est_d;
   logic [2:0]               sinc_q, sinc_d;
   logic [ANCHO_PERIODO-1:0] cnt_q, cnt_d;
   logic [ANCHO_PERIODO:0]   div_q, div_d, rem_q, rem_d;
   logic [ANCHO_DIV-1:0]     quo_q, quo_d;
   logic [AC-1:0]            it_q, it_d;
   logic [9:0]               tono_q, tono_d;
   logic                     valido_q, valido_d, sil_q, sil_d;

   logic                     flanco, bit_c;
   logic [ANCHO_PERIODO:0]   periodo, resta;
   logic [ANCHO_PERIODO+1:0] prueba;
   logic [ANCHO_DIV-1:0]     cociente;

   always_ff @(posedge clk_periodo) begin
      if (reset) begin
         est_q    <= ESPERA;
         sinc_q   <= '0;
         cnt_q    <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         it_q     <= '0;
         tono_q   <= '0;
         valido_q <= 1'b0;
         sil_q    <= 1'b1;
      end else begin
         est_q    <= est_d;
         sinc_q   <= sinc_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         it_q     <= it_d;
         tono_q   <= tono_d;
         valido_q <= valido_d;
         sil_q    <= sil_d;
      end
   end

   always_comb begin
      // sinc_q[1] is the synchronized pin, sinc_q[2] its previous value
      sinc_d   = {sinc_q[1:0], onda_entrada};
      flanco   = sinc_q[1] & ~sinc_q[2];
      periodo  = (ANCHO_PERIODO+1)'(cnt_q) + UNO;
      // remainder is always < divisor, so the low bits of the subtraction are exact
      prueba   = {rem_q, quo_q[ANCHO_DIV-1]};
      bit_c    = (prueba >= {1'b0, div_q});
      resta    = prueba[ANCHO_PERIODO:0] - div_q;
      cociente = {quo_q[ANCHO_DIV-2:0], bit_c};

      est_d    = est_q;
      div_d    = div_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      it_d     = it_q;
      tono_d   = tono_q;
      valido_d = 1'b0;
      sil_d    = sil_q;

      if (flanco)                cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      else                       cnt_d = cnt_q;

      case (est_q)
         ESPERA: begin
            if (flanco) est_d = MIDIENDO;
         end
         MIDIENDO: begin
            if (flanco) begin
               div_d = periodo;
               rem_d = '0;
               quo_d = DIVIDENDO;
               it_d  = '0;
               est_d = DIVIDIENDO;
            end else if (cnt_q == CNT_MAX) begin
               sil_d  = 1'b1;
               tono_d = '0;
               est_d  = ESPERA;
            end
         end
         DIVIDIENDO: begin
            // edges seen here only restart the period counter
            rem_d = bit_c ? resta : prueba[ANCHO_PERIODO:0];
            quo_d = cociente;
            it_d  = it_q + 1'b1;
            if (it_q == IT_ULT) begin
               tono_d   = (cociente > TMAX) ? TMAX10 : cociente[9:0];
               valido_d = 1'b1;
               sil_d    = 1'b0;
               est_d    = MIDIENDO;
            end
         end
         default: est_d = ESPERA;
      endcase
   end

   assign tono        = tono_q;
   assign tono_valido = valido_q;
   assign silencio    = sil_q;
   assign ocupado     = (est_q == DIVIDIENDO);

endmodule

// File: tb/tb_medidor_de_frecuencia.sv
// Scoreboard bench for medidor_de_frecuencia, run with a scaled clock (120 kHz, 6000-cycle silence).
module tb_medidor_de_frecuencia;

   localparam int CLK_HZ = 120000;
   localparam int MAXP   = 6000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       onda = 1'b0;
   logic [9:0] tono;
   logic       tono_valido, silencio, ocupado;

   typedef struct {int tono; int cyc;} esp_t;
   esp_t q[$];
   esp_t m_e;

   int nvec = 0, nerr = 0, cyc = 0, ult_T = 1, ult_cyc = 0, n0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   medidor_de_frecuencia #(.CLK_HZ(CLK_HZ), .MAX_PERIODO(MAXP)) dut (
      .clk_periodo (clk),
      .reset       (reset),
      .onda_entrada(onda),
      .tono        (tono),
      .tono_valido (tono_valido),
      .silencio    (silencio),
      .ocupado     (ocupado)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      nvec++;
      if (obs != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hasta(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   // rising edge on the pin; if medir, the period ending here must be reported 27 cycles later
   task automatic subida(input bit medir);
      esp_t e;
      if (medir) begin
         e.tono = (CLK_HZ / ult_T > 1023) ? 1023 : CLK_HZ / ult_T;
         e.cyc  = cyc + 27;
         q.push_back(e);
      end
      ult_cyc = cyc;
      onda = 1'b1;
   endtask

   task automatic periodo(input int T, input bit medir);
      subida(medir);
      ult_T = T;
      tick(T / 2);
      onda = 1'b0;
      tick(T - T / 2);
   endtask

   always @(negedge clk) begin
      if (tono_valido) begin
         if (q.size() == 0) chk("valido_extra", int'(tono_valido), 0);
         else begin
            m_e = q.pop_front();
            chk("tono", int'(tono), m_e.tono);
            chk("latencia", cyc, m_e.cyc);
         end
      end
      if (q.size() > 0 && cyc > q[0].cyc) begin
         chk("valido_perdido", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (silencio && tono_valido) chk("sil_y_valido", int'(silencio & tono_valido), 0);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      tick(3);
      @(negedge clk);
      chk("rst_tono", int'(tono), 0);
      chk("rst_valido", int'(tono_valido), 0);
      chk("rst_silencio", int'(silencio), 1);
      chk("rst_ocupado", int'(ocupado), 0);
      reset = 1'b0;
      tick(5);

      // first edge only sets the reference; silence holds until a measurement lands
      periodo(272, 0);
      chk("sil_inicial", int'(silencio), 1);
      periodo(272, 1);
      periodo(120, 1);
      periodo(110, 1);
      periodo(364, 1);
      periodo(458, 1);
      chk("sil_medido", int'(silencio), 0);
      periodo(6000, 1);
      periodo(100, 1);

      // last edge, then silence timeout
      ult_T = 100;
      subida(1);
      n0 = ult_cyc;
      hasta(n0 + 2);  chk("ocup_antes", int'(ocupado), 0);
      hasta(n0 + 3);  chk("ocup_ini", int'(ocupado), 1);
      onda = 1'b0;
      hasta(n0 + 26); chk("ocup_fin", int'(ocupado), 1);
      hasta(n0 + 27); chk("ocup_libre", int'(ocupado), 0);
      hasta(n0 + MAXP + 3);
      chk("sil_previo", int'(silencio), 0);
      chk("tono_previo", int'(tono), 1023);
      hasta(n0 + MAXP + 4);
      chk("sil_timeout", int'(silencio), 1);
      chk("tono_timeout", int'(tono), 0);
      tick(1);

      // after silence: first edge is reference only, next one measures
      periodo(300, 0);
      periodo(40, 1);
      chk("sil_tras_medida", int'(silencio), 0);

      // reset in the middle of a division
      subida(0);
      n0 = ult_cyc;
      tick(5);
      onda = 1'b0;
      hasta(n0 + 10);
      chk("ocup_pre_rst", int'(ocupado), 1);
      reset = 1'b1;
      hasta(n0 + 11);
      chk("rstdiv_tono", int'(tono), 0);
      chk("rstdiv_sil", int'(silencio), 1);
      chk("rstdiv_ocup", int'(ocupado), 0);
      chk("rstdiv_valido", int'(tono_valido), 0);
      reset = 1'b0;
      tick(40);

      // P=2 saturates; edge during division is dropped but becomes the new reference
      periodo(2, 0);
      periodo(500, 1);
      periodo(20, 1);
      periodo(150, 0);
      periodo(60, 1);
      tick(40);
      chk("pendientes", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
